// File: rtl/clk_pulse_pkg.sv
// Shared edge_mode encodings, parameter limits and the edge qualifier
// used by every clk_pulse_multi channel.
package clk_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned CHANNELS_MIN    = 1;
    localparam int unsigned CHANNELS_MAX    = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned PULSE_LEN_MIN   = 1;
    localparam int unsigned PULSE_LEN_MAX   = 255;

    // Stretch counter width fixed by the largest PULSE_LEN.
    localparam int unsigned STRETCH_W = 8;
    // Arming counter must reach SYNC_STAGES_MAX + 1.
    localparam int unsigned ARM_W     = 3;

    function automatic logic edge_qualify(logic [1:0] mode, logic rise, logic fall);
        logic q;
        q = 1'b0;
        unique case (edge_mode_e'(mode))
            MODE_OFF:  q = 1'b0;
            MODE_RISE: q = rise;
            MODE_FALL: q = fall;
            MODE_BOTH: q = rise | fall;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/clk_pulse_chan.sv
// One channel: synchroniser, edge detector, pulse stretcher and, when
// CLK_PULSE_CNT_EN is defined, a wrapping edge counter with synchronous clear.
module clk_pulse_chan
    import clk_pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sig_i,
    input  logic [1:0]           edge_mode_i,
    input  logic                 armed_i,
    input  logic                 cnt_clr_i,
    output logic                 pulse_o,
    output logic [CNT_WIDTH-1:0] edge_cnt_o
);

    localparam logic [STRETCH_W-1:0] RELOAD = STRETCH_W'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [STRETCH_W-1:0]   stretch_q, stretch_d;
    logic                   pulse_q, pulse_d;
    logic                   sync_lvl, rise, fall, hit;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~prev_q;
    assign fall     = ~sync_lvl & prev_q;
    assign hit      = armed_i & edge_qualify(edge_mode_i, rise, fall);

    // pulse_out is registered off the stretch counter, which puts the first
    // high cycle on the (SYNC_STAGES+1)th edge after the input is sampled.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_i};
        prev_d    = sync_lvl;
        stretch_d = stretch_q;
        if (hit) begin
            stretch_d = RELOAD;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - STRETCH_W'(1);
        end
        pulse_d = (stretch_q != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            stretch_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            stretch_q <= stretch_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

`ifdef CLK_PULSE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (hit) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign edge_cnt_o = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign edge_cnt_o     = '0;
`endif

endmodule

// File: rtl/clk_pulse_multi.sv
// Multi-channel asynchronous edge to clk-domain pulse converter.
// Define CLK_PULSE_CNT_EN to enable the per-channel edge counters on edge_cnt.
module clk_pulse_multi
    import clk_pulse_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           sig_in,
    input  logic [2*CHANNELS-1:0]         edge_mode,
    input  logic [CHANNELS-1:0]           cnt_clr,
    output logic [CHANNELS-1:0]           pulse_out,
    output logic [CHANNELS*CNT_WIDTH-1:0] edge_cnt
);

    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [ARM_W-1:0] arm_q, arm_d;
    logic             armed;

    // Hold off detection until the synchronisers have flushed reset-time levels.
    assign armed = (arm_q == ARM_DONE);

    always_comb begin
        arm_d = arm_q;
        if (!armed) begin
            arm_d = arm_q + ARM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= '0;
        end else begin
            arm_q <= arm_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .sig_i       (sig_in[i]),
            .edge_mode_i (edge_mode[2*i +: 2]),
            .armed_i     (armed),
            .cnt_clr_i   (cnt_clr[i]),
            .pulse_o     (pulse_out[i]),
            .edge_cnt_o  (edge_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_clk_pulse_multi.sv
// Bench for clk_pulse_multi: two instances (PULSE_LEN 1 / 5) checked against a
// sample-history reference model plus directed scenario expectations.
module tb_clk_pulse_multi;

    localparam int CH    = 4;
    localparam int SS    = 2;
    localparam int LEN_A = 1;
    localparam int W_A   = 16;
    localparam int LEN_B = 5;
    localparam int W_B   = 4;
    localparam int HIST  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sig_in = '0;
    logic [7:0]  edge_mode = '0;
    logic [3:0]  cnt_clr = '0;
    logic [3:0]  pulse_a, pulse_b;
    logic [63:0] cnt_a;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_pulse_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_LEN(LEN_A), .CNT_WIDTH(W_A)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .edge_mode(edge_mode),
        .cnt_clr(cnt_clr), .pulse_out(pulse_a), .edge_cnt(cnt_a)
    );

    clk_pulse_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_LEN(LEN_B), .CNT_WIDTH(W_B)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .edge_mode(edge_mode),
        .cnt_clr(cnt_clr), .pulse_out(pulse_b), .edge_cnt(cnt_b)
    );

    // Input history: index n holds what the nth clk edge after reset release sampled.
    int         cyc;
    logic [3:0] s_hist   [0:HIST-1];
    logic [7:0] md_hist  [0:HIST-1];
    logic [3:0] clr_hist [0:HIST-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc         <= 0;
            s_hist[0]   <= '0;
            md_hist[0]  <= '0;
            clr_hist[0] <= '0;
        end else if (cyc < HIST - 1) begin
            cyc             <= cyc + 1;
            s_hist[cyc+1]   <= sig_in;
            md_hist[cyc+1]  <= edge_mode;
            clr_hist[cyc+1] <= cnt_clr;
        end
    end

    // An input change sampled at edge k is seen by the detector in the cycle
    // before edge k+SS; detection is armed only SS+1 edges after release.
    function automatic bit qual(int ch, int k);
        logic       a, b;
        logic [1:0] m;
        if (k + SS - 1 < SS + 1 || k + SS > cyc) return 1'b0;
        a = s_hist[k-1][ch];
        b = s_hist[k][ch];
        m = md_hist[k+SS][2*ch +: 2];
        if (a == b) return 1'b0;
        return b ? m[0] : m[1];
    endfunction

    // Pulse is high on edges k+SS+1 .. k+SS+len for every qualified edge k.
    function automatic logic [3:0] exp_pulse(int len);
        logic [3:0] v;
        v = '0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int k = cyc - SS - len; k <= cyc - SS - 1; k++) begin
                if (qual(ch, k)) v[ch] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic int exp_cnt(int ch, int w);
        int c;
        c = 0;
        for (int d = 1; d <= cyc; d++) begin
            if (clr_hist[d][ch]) c = 0;
            else if (qual(ch, d - SS)) c = (c + 1) % (1 << w);
        end
`ifndef CLK_PULSE_CNT_EN
        c = 0;
`endif
        return c;
    endfunction

    task automatic test_reset();
        int ec;
        rst_n = 1'b0; sig_in = 4'hF; edge_mode = 8'hFF; cnt_clr = '0;
        repeat (3) @(negedge clk);
        total += 2;
        if ({pulse_a, pulse_b} !== 8'h00) begin
            bad++; $display("FAIL reset_pulse got=%b_%b want=0", pulse_a, pulse_b);
        end
        if ({cnt_a, cnt_b} !== 80'h0) begin
            bad++; $display("FAIL reset_cnt got=%h_%h want=0", cnt_a, cnt_b);
        end
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk); #1;
            total++;
            if ({pulse_a, pulse_b} !== 8'h00) begin
                bad++; $display("FAIL reset_arm j=%0d got=%b_%b want=0", j, pulse_a, pulse_b);
            end
            for (int ch = 0; ch < CH; ch++) begin
                ec = exp_cnt(ch, W_A); total++;
                if (cnt_a[ch*W_A +: W_A] !== W_A'(ec)) begin
                    bad++; $display("FAIL reset_cnt_a ch=%0d got=%0d want=%0d", ch,
                                    cnt_a[ch*W_A +: W_A], ec);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [3:0] ep_a, ep_b;
        edge_mode = 8'h01; cnt_clr = '0;
        @(negedge clk); sig_in = 4'h0;
        repeat (5) @(negedge clk);
        for (int j = 1; j <= 18; j++) begin
            if (j == 1) sig_in[0] = 1'b1;
            if (j == 10) sig_in[0] = 1'b0;
            @(posedge clk); #1;
            ep_a = exp_pulse(LEN_A); ep_b = exp_pulse(LEN_B);
            total += 4;
            if (pulse_a[0] !== (j == 4)) begin
                bad++; $display("FAIL single_latency_a j=%0d got=%b want=%b", j, pulse_a[0], j == 4);
            end
            if (pulse_b[0] !== (j >= 4 && j <= 8)) begin
                bad++; $display("FAIL single_len_b j=%0d got=%b", j, pulse_b[0]);
            end
            if (pulse_a !== ep_a) begin
                bad++; $display("FAIL single_model_a cyc=%0d got=%b want=%b", cyc, pulse_a, ep_a);
            end
            if (pulse_b !== ep_b) begin
                bad++; $display("FAIL single_model_b cyc=%0d got=%b want=%b", cyc, pulse_b, ep_b);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] ep_b;
        int         want;
`ifdef CLK_PULSE_CNT_EN
        want = 2;
`else
        want = 0;
`endif
        edge_mode = 8'b00_00_11_00;
        for (int j = 1; j <= 16; j++) begin
            if (j == 1) begin sig_in[1] = 1'b1; cnt_clr = 4'hF; end
            if (j == 2) cnt_clr = 4'h0;
            if (j == 4) sig_in[1] = 1'b0;
            @(posedge clk); #1;
            ep_b = exp_pulse(LEN_B);
            total += 3;
            if (pulse_b[1] !== (j >= 4 && j <= 11)) begin
                bad++; $display("FAIL retrig_b j=%0d got=%b", j, pulse_b[1]);
            end
            if (pulse_a[1] !== (j == 4 || j == 7)) begin
                bad++; $display("FAIL retrig_a j=%0d got=%b", j, pulse_a[1]);
            end
            if (pulse_b !== ep_b) begin
                bad++; $display("FAIL retrig_model_b cyc=%0d got=%b want=%b", cyc, pulse_b, ep_b);
            end
            @(negedge clk);
        end
        total += 2;
        if (cnt_b[7:4] !== 4'(want)) begin
            bad++; $display("FAIL retrig_cnt_b got=%0d want=%0d", cnt_b[7:4], want);
        end
        if (cnt_a[31:16] !== 16'(want)) begin
            bad++; $display("FAIL retrig_cnt_a got=%0d want=%0d", cnt_a[31:16], want);
        end
    endtask

    task automatic test_wrap();
        int ec;
        int want_a, want_b;
`ifdef CLK_PULSE_CNT_EN
        want_a = 17; want_b = 1;
`else
        want_a = 0; want_b = 0;
`endif
        edge_mode = 8'b00_01_00_00; cnt_clr = 4'b0100;
        @(negedge clk); cnt_clr = '0;
        for (int j = 1; j <= 72; j++) begin
            sig_in[2] = (j <= 68) ? (((j - 1) / 2) % 2 == 0) : 1'b0;
            @(posedge clk); #1;
            ec = exp_cnt(2, W_B); total++;
            if (cnt_b[11:8] !== 4'(ec)) begin
                bad++; $display("FAIL wrap_model_b cyc=%0d got=%0d want=%0d", cyc, cnt_b[11:8], ec);
            end
            @(negedge clk);
        end
        total += 2;
        if (cnt_b[11:8] !== 4'(want_b)) begin
            bad++; $display("FAIL wrap_cnt_b got=%0d want=%0d", cnt_b[11:8], want_b);
        end
        if (cnt_a[47:32] !== 16'(want_a)) begin
            bad++; $display("FAIL wrap_cnt_a got=%0d want=%0d", cnt_a[47:32], want_a);
        end
        // Clear lands on the same edge as the increment of this rise.
        for (int j = 1; j <= 8; j++) begin
            if (j == 1) sig_in[2] = 1'b1;
            cnt_clr[2] = (j == 3);
            @(posedge clk); #1;
            total++;
            if (pulse_a[2] !== (j == 4)) begin
                bad++; $display("FAIL clr_edge_pulse j=%0d got=%b", j, pulse_a[2]);
            end
            @(negedge clk);
        end
        total += 2;
        if (cnt_b[11:8] !== 4'h0) begin
            bad++; $display("FAIL clr_prio_b got=%0d want=0", cnt_b[11:8]);
        end
        if (cnt_a[47:32] !== 16'h0) begin
            bad++; $display("FAIL clr_prio_a got=%0d want=0", cnt_a[47:32]);
        end
    endtask

    task automatic test_slow_clocks();
        int   off0, off3, falls0, falls3, seen0, seen3;
        logic n0, n3;
        logic [3:0] ep_a;
        falls0 = 0; falls3 = 0; seen0 = 0; seen3 = 0;
        edge_mode = 8'b10_00_00_10; sig_in = 4'h0; cnt_clr = '0;
        repeat (4) @(negedge clk);
        off0 = int'($urandom_range(0, 19));
        off3 = int'($urandom_range(0, 27));
        for (int j = 1; j <= 506; j++) begin
            if (j <= 500) begin
                n0 = (((j + off0) / 10) % 2) == 1;
                n3 = (((j + off3) / 14) % 2) == 1;
                if (sig_in[0] && !n0) falls0++;
                if (sig_in[3] && !n3) falls3++;
                sig_in[0] = n0;
                sig_in[3] = n3;
            end
            @(posedge clk); #1;
            seen0 += int'(pulse_a[0]);
            seen3 += int'(pulse_a[3]);
            ep_a = exp_pulse(LEN_A); total++;
            if (pulse_a !== ep_a) begin
                bad++; $display("FAIL slow_model_a cyc=%0d got=%b want=%b", cyc, pulse_a, ep_a);
            end
            @(negedge clk);
        end
        total += 2;
        if (seen0 !== falls0) begin
            bad++; $display("FAIL slow_ch0 pulses=%0d falls=%0d", seen0, falls0);
        end
        if (seen3 !== falls3) begin
            bad++; $display("FAIL slow_ch3 pulses=%0d falls=%0d", seen3, falls3);
        end
    endtask

    task automatic test_random();
        int         hold [4];
        int         ec;
        logic [3:0] ep_a, ep_b;
        for (int ch = 0; ch < CH; ch++) hold[ch] = 3;
        for (int j = 1; j <= 600; j++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (hold[ch] == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        sig_in[ch] = ~sig_in[ch];
                        hold[ch]   = int'($urandom_range(2, 6));
                    end
                end else begin
                    hold[ch]--;
                end
            end
            if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
            cnt_clr = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
            @(posedge clk); #1;
            ep_a = exp_pulse(LEN_A); ep_b = exp_pulse(LEN_B);
            total += 2;
            if (pulse_a !== ep_a) begin
                bad++; $display("FAIL rand_pulse_a cyc=%0d got=%b want=%b", cyc, pulse_a, ep_a);
            end
            if (pulse_b !== ep_b) begin
                bad++; $display("FAIL rand_pulse_b cyc=%0d got=%b want=%b", cyc, pulse_b, ep_b);
            end
            for (int ch = 0; ch < CH; ch++) begin
                ec = exp_cnt(ch, W_A); total++;
                if (cnt_a[ch*W_A +: W_A] !== W_A'(ec)) begin
                    bad++; $display("FAIL rand_cnt_a cyc=%0d ch=%0d got=%0d want=%0d", cyc, ch,
                                    cnt_a[ch*W_A +: W_A], ec);
                end
                ec = exp_cnt(ch, W_B); total++;
                if (cnt_b[ch*W_B +: W_B] !== W_B'(ec)) begin
                    bad++; $display("FAIL rand_cnt_b cyc=%0d ch=%0d got=%0d want=%0d", cyc, ch,
                                    cnt_b[ch*W_B +: W_B], ec);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] ep_b;
        sig_in = 4'h0; edge_mode = 8'b00_00_01_00; cnt_clr = '0;
        repeat (4) @(negedge clk);
        for (int j = 1; j <= 6; j++) begin
            if (j == 1) sig_in[1] = 1'b1;
            @(posedge clk); #1;
            if (j == 6) begin
                total++;
                if (pulse_b[1] !== 1'b1) begin
                    bad++; $display("FAIL mid_pulse_live got=%b want=1", pulse_b[1]);
                end
            end
            if (j < 6) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if ({pulse_a, pulse_b} !== 8'h00) begin
            bad++; $display("FAIL mid_reset_drop got=%b_%b want=0", pulse_a, pulse_b);
        end
        if ({cnt_a, cnt_b} !== 80'h0) begin
            bad++; $display("FAIL mid_reset_cnt got=%h_%h want=0", cnt_a, cnt_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk); #1;
            ep_b = exp_pulse(LEN_B);
            total += 2;
            if ({pulse_a, pulse_b} !== 8'h00) begin
                bad++; $display("FAIL mid_no_resume j=%0d got=%b_%b", j, pulse_a, pulse_b);
            end
            if (pulse_b !== ep_b) begin
                bad++; $display("FAIL mid_model_b cyc=%0d got=%b want=%b", cyc, pulse_b, ep_b);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_retrigger();
        test_wrap();
        test_slow_clocks();
        test_random();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
